// File: rtl/mult_pkg.sv
`timescale 1ns/1ps
// Shared types and widths for the multiplier -> accumulator path.
package mult_pkg;
  localparam int PW_DEF    = 16;  // m+n of the 8x8 multiplier stage
  localparam int ACC_W_DEF = 24;
  localparam int CNT_W_DEF = 4;

  localparam logic [ACC_W_DEF-1:0] SAT_MAX = '1;

  typedef enum logic {ACC, HOLD} state_e;
endpackage

// File: rtl/product_accumulator_if.sv
`timescale 1ns/1ps
// Product-in / block-sum-out handshake bundle for product_accumulator.
interface product_accumulator_if import mult_pkg::*; #(
  parameter int PW    = PW_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic [PW-1:0]    prod;
  logic             prod_valid;
  logic             prod_ready;
  logic [CNT_W-1:0] blk_len;
  logic             flush;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] sum_cnt;
  logic             sum_sat;
  logic             sum_valid;
  logic             sum_ready;

  modport master (
    output prod, prod_valid, blk_len, flush, sum_ready,
    input  prod_ready, sum, sum_cnt, sum_sat, sum_valid
  );
  modport slave (
    input  prod, prod_valid, blk_len, flush, sum_ready,
    output prod_ready, sum, sum_cnt, sum_sat, sum_valid
  );
endinterface

// File: rtl/sat_adder.sv
`timescale 1ns/1ps
// Combinational saturating add of a zero-extended product into an accumulator.
module sat_adder #(
  parameter int ACC_W = 24,
  parameter int PW    = 16
) (
  input  logic [ACC_W-1:0] a,
  input  logic [PW-1:0]    b,
  output logic [ACC_W-1:0] s,
  output logic             ovf
);
  logic [ACC_W:0] raw;

  assign raw = {1'b0, a} + {{(ACC_W+1-PW){1'b0}}, b};
  assign ovf = raw[ACC_W];
  // A carry-out clamps to all ones; an already-clamped acc stays clamped.
  assign s   = ovf ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
endmodule

// File: rtl/product_accumulator.sv
`timescale 1ns/1ps
// Sums blocks of multiplier products into a saturating accumulator and
// presents each block sum on a valid/ready output.
module product_accumulator import mult_pkg::*; #(
  parameter int PW    = PW_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  product_accumulator_if.slave  bus
);
  state_e           state, state_nx;
  logic [ACC_W-1:0] acc, acc_nx, add_s;
  logic [CNT_W-1:0] cnt, cnt_nx, len_q, len_eff;
  logic             sat_q, sat_nx, add_ovf;
  logic [ACC_W-1:0] sum_r;
  logic [CNT_W-1:0] cnt_r;
  logic             sat_r;
  logic             accept, out_hs, first;

  assign accept  = bus.prod_valid & bus.prod_ready;
  assign out_hs  = bus.sum_valid & bus.sum_ready;
  assign first   = (cnt == '0);
  // Length is latched from the first product; zero means single-product blocks.
  assign len_eff = first ? ((bus.blk_len == '0) ? CNT_W'(1) : bus.blk_len) : len_q;

  sat_adder #(.ACC_W(ACC_W), .PW(PW)) u_add (
    .a(acc), .b(bus.prod), .s(add_s), .ovf(add_ovf)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ACC;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ACC: begin
        if (accept && (cnt_nx == len_eff || bus.flush)) state_nx = HOLD;
        else if (!accept && bus.flush && !first)         state_nx = HOLD;
      end
      HOLD: if (out_hs) state_nx = ACC;
      default: state_nx = ACC;
    endcase
  end

  always_comb begin
    bus.prod_ready = (state == ACC);
    bus.sum_valid  = (state == HOLD);
  end

  always_comb begin
    acc_nx = acc;
    cnt_nx = cnt;
    sat_nx = sat_q;
    if (accept) begin
      acc_nx = add_s;
      cnt_nx = cnt + CNT_W'(1);
      sat_nx = sat_q | add_ovf;
    end else if (out_hs) begin
      acc_nx = '0;
      cnt_nx = '0;
      sat_nx = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc   <= '0;
      cnt   <= '0;
      sat_q <= 1'b0;
      len_q <= '0;
      sum_r <= '0;
      cnt_r <= '0;
      sat_r <= 1'b0;
    end else begin
      acc   <= acc_nx;
      cnt   <= cnt_nx;
      sat_q <= sat_nx;
      if (accept && first) len_q <= len_eff;
      // Output regs snapshot the closing block so they hold after the handshake.
      if (state == ACC && state_nx == HOLD) begin
        sum_r <= acc_nx;
        cnt_r <= cnt_nx;
        sat_r <= sat_nx;
      end
    end
  end

  assign bus.sum     = sum_r;
  assign bus.sum_cnt = cnt_r;
  assign bus.sum_sat = sat_r;
endmodule
